// File: rtl/nes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module   : nes_pad_responder
//  Purpose  : Device-side model of an NES game pad (4021-style shift register).
//             Answers the console reader's latch/clock pulses and returns the
//             eight button bits serially, A first, active-low.
//  Revision : 1.0  initial release
//
//  Ports
//    clk_25mhz   in   1  system clock
//    rst         in   1  asynchronous active-high reset
//    latch_in    in   1  latch from reader (async), high = parallel load
//    pclk_in     in   1  serial clock from reader (async), rise = next bit
//    buttons     in   8  pressed=1, {Right,Left,Down,Up,Start,Select,B,A}
//    data_out    out  1  serial data, pressed bit drives 0
//    shift_cnt   out  4  bits shifted since last latch, saturates at 15
//    frame_done  out  1  pulse when the 8th bit has been shifted
//    short_frame out  1  pulse when a latch arrives after 1..7 shifts
//    extra_clk   out  1  sticky: pclk rise seen after the 8th shift
// ============================================================================
module nes_pad_responder #(
  parameter int   FILT_CYC = 2,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       latch_in,
  input  logic       pclk_in,
  input  logic [7:0] buttons,
  output logic       data_out,
  output logic [3:0] shift_cnt,
  output logic       frame_done,
  output logic       short_frame,
  output logic       extra_clk
);

  localparam logic [3:0] FILT_LIM = 4'(FILT_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index 0 = latch_in, index 1 = pclk_in.
  logic [1:0] raw_w;
  logic [1:0] rise_w;
  logic [1:0] fall_w;

  assign raw_w = {pclk_in, latch_in};

  // --------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, then a level filter. The filter
  // counts consecutive samples that disagree with the accepted level; any
  // sample agreeing with the accepted level restarts the count.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_cond
    logic       sync1_q, sync2_q;
    logic       filt_q,  filt_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       rise_q,  fall_q;

    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (sync2_q == filt_q) begin
        cnt_d = '0;
      end else if ((cnt_q + 4'd1) >= FILT_LIM) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        filt_q  <= 1'b0;
        cnt_q   <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync1_q <= raw_w[gi];
        sync2_q <= sync1_q;
        filt_q  <= filt_d;
        cnt_q   <= cnt_d;
        rise_q  <= filt_d & ~filt_q;
        fall_q  <= ~filt_d & filt_q;
      end
    end

    assign rise_w[gi] = rise_q;
    assign fall_w[gi] = fall_q;
  end : g_cond

  logic latch_rise_w, latch_fall_w, pclk_rise_w;
  assign latch_rise_w = rise_w[0];
  assign latch_fall_w = fall_w[0];
  assign pclk_rise_w  = rise_w[1];

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  state_t     state_q,       state_d;
  logic [7:0] sreg_q,        sreg_d;
  logic [3:0] shift_cnt_q,   shift_cnt_d;
  logic       frame_done_q,  frame_done_d;
  logic       short_frame_q, short_frame_d;
  logic       extra_clk_q,   extra_clk_d;
  logic       data_out_q,    data_out_d;

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    shift_cnt_d   = shift_cnt_q;
    frame_done_d  = 1'b0;
    short_frame_d = 1'b0;
    extra_clk_d   = extra_clk_q;

    // A latch rise always wins over a coincident pclk rise.
    if (latch_rise_w) begin
      extra_clk_d = 1'b0;
      if (state_q == SHIFT && shift_cnt_q != 4'd0) begin
        short_frame_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (latch_rise_w) begin
          state_d     = LOAD;
          sreg_d      = buttons;
          shift_cnt_d = '0;
        end
      end
      LOAD: begin
        // Transparent parallel load while the latch is held high.
        sreg_d      = buttons;
        shift_cnt_d = '0;
        if (latch_fall_w) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (latch_rise_w) begin
          state_d     = LOAD;
          sreg_d      = buttons;
          shift_cnt_d = '0;
        end else if (pclk_rise_w) begin
          sreg_d      = {1'b0, sreg_q[7:1]};
          shift_cnt_d = shift_cnt_q + 4'd1;
          if (shift_cnt_q == 4'd7) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        if (latch_rise_w) begin
          state_d     = LOAD;
          sreg_d      = buttons;
          shift_cnt_d = '0;
        end else if (pclk_rise_w) begin
          extra_clk_d = 1'b1;
          if (shift_cnt_q != 4'hF) begin
            shift_cnt_d = shift_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered data line follows the next-state view of the frame.
    case (state_d)
      IDLE:    data_out_d = 1'b1;
      DONE:    data_out_d = FILL_BIT;
      default: data_out_d = ~sreg_d[0];
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sreg_q        <= '0;
      shift_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      extra_clk_q   <= 1'b0;
      data_out_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      shift_cnt_q   <= shift_cnt_d;
      frame_done_q  <= frame_done_d;
      short_frame_q <= short_frame_d;
      extra_clk_q   <= extra_clk_d;
      data_out_q    <= data_out_d;
    end
  end

  assign data_out    = data_out_q;
  assign shift_cnt   = shift_cnt_q;
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;
  assign extra_clk   = extra_clk_q;

endmodule : nes_pad_responder
`default_nettype wire

// File: tb/tb_nes_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nes_pad_responder
//  Purpose  : Self-checking bench for nes_pad_responder. Expected serial bits
//             are derived from the applied buttons and queued when a frame is
//             started; each is popped and compared before the pclk rise that
//             would advance past it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nes_pad_responder;

  localparam int   FILT_CYC = 2;
  localparam logic FILL_BIT = 1'b0;

  logic       clk_25mhz = 1'b0;
  logic       rst       = 1'b1;
  logic       latch_in  = 1'b0;
  logic       pclk_in   = 1'b0;
  logic [7:0] buttons   = 8'h00;
  logic       data_out;
  logic [3:0] shift_cnt;
  logic       frame_done;
  logic       short_frame;
  logic       extra_clk;

  nes_pad_responder #(
    .FILT_CYC (FILT_CYC),
    .FILL_BIT (FILL_BIT)
  ) dut (
    .clk_25mhz   (clk_25mhz),
    .rst         (rst),
    .latch_in    (latch_in),
    .pclk_in     (pclk_in),
    .buttons     (buttons),
    .data_out    (data_out),
    .shift_cnt   (shift_cnt),
    .frame_done  (frame_done),
    .short_frame (short_frame),
    .extra_clk   (extra_clk)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_fd  = 0;
  int   n_sf  = 0;
  logic sb[$];

  always @(negedge clk_25mhz) begin
    if (frame_done)  n_fd++;
    if (short_frame) n_sf++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic do_latch(input logic [7:0] b);
    buttons  = b;
    latch_in = 1'b1;
    wait_cyc(12);
    latch_in = 1'b0;
    wait_cyc(6);
  endtask

  // Expected bit for each of n pulses: A first, active-low, then fill level.
  task automatic push_frame(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < 8) sb.push_back(~b[i]);
      else       sb.push_back(FILL_BIT);
    end
  endtask

  task automatic pclk_pulse(input int hi, input int lo);
    pclk_in = 1'b1;
    wait_cyc(hi);
    pclk_in = 1'b0;
    wait_cyc(lo);
  endtask

  task automatic shift_check(input int n);
    logic exp;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        check_eq("data_bit", 32'(data_out), 32'(exp));
      end
      pclk_pulse(6, 6);
    end
  endtask

  initial begin
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(10);

    // Reset then idle
    check_eq("idle_data", 32'(data_out), 32'd1);
    check_eq("idle_cnt",  32'(shift_cnt), 32'd0);
    check_eq("idle_flags", {29'd0, frame_done, short_frame, extra_clk}, 32'd0);

    // Nominal frame, A + Right
    n_fd = 0;
    do_latch(8'h81);
    push_frame(8'h81, 8);
    shift_check(8);
    wait_cyc(4);
    check_eq("nom_fill", 32'(data_out), 32'(FILL_BIT));
    check_eq("nom_cnt",  32'(shift_cnt), 32'd8);
    check_eq("nom_fd",   32'(n_fd), 32'd1);
    check_eq("nom_extra", 32'(extra_clk), 32'd0);

    // Glitch rejection
    do_latch(8'h05);
    pclk_pulse(1, 8);
    check_eq("glitch_cnt",  32'(shift_cnt), 32'd0);
    check_eq("glitch_data", 32'(data_out), 32'd0);
    pclk_pulse(2, 8);
    check_eq("pulse2_cnt",  32'(shift_cnt), 32'd1);
    check_eq("pulse2_data", 32'(data_out), 32'd1);

    // Short frame and reload
    do_latch(8'h0F);
    push_frame(8'h0F, 3);
    shift_check(3);
    n_sf = 0;
    buttons  = 8'hF0;
    latch_in = 1'b1;
    wait_cyc(8);
    check_eq("short_cnt",   32'(shift_cnt), 32'd0);
    check_eq("short_pulse", 32'(n_sf), 32'd1);
    wait_cyc(4);
    latch_in = 1'b0;
    wait_cyc(6);
    push_frame(8'hF0, 8);
    shift_check(8);
    check_eq("short_once", 32'(n_sf), 32'd1);

    // Latch with zero shifts gives no short pulse
    n_sf = 0;
    do_latch(8'h11);
    do_latch(8'h22);
    check_eq("zero_short", 32'(n_sf), 32'd0);
    push_frame(8'h22, 1);
    shift_check(1);

    // Over-clocking
    n_fd = 0;
    do_latch(8'h3C);
    push_frame(8'h3C, 11);
    shift_check(11);
    wait_cyc(2);
    check_eq("over_fd",    32'(n_fd), 32'd1);
    check_eq("over_extra", 32'(extra_clk), 32'd1);
    check_eq("over_cnt",   32'(shift_cnt), 32'd11);
    buttons  = 8'h5A;
    latch_in = 1'b1;
    wait_cyc(8);
    check_eq("latch_clr_extra", 32'(extra_clk), 32'd0);
    check_eq("latch_clr_cnt",   32'(shift_cnt), 32'd0);
    wait_cyc(4);
    latch_in = 1'b0;
    wait_cyc(6);

    // Saturation at 15
    push_frame(8'h5A, 17);
    shift_check(17);
    check_eq("sat_cnt",   32'(shift_cnt), 32'd15);
    check_eq("sat_extra", 32'(extra_clk), 32'd1);

    // Async reset while extra_clk is set
    rst = 1'b1;
    #1;
    check_eq("rst1_extra", 32'(extra_clk), 32'd0);
    check_eq("rst1_cnt",   32'(shift_cnt), 32'd0);
    check_eq("rst1_data",  32'(data_out), 32'd1);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);

    // No latch yet: clocks must be ignored
    pclk_pulse(6, 6);
    pclk_pulse(6, 6);
    check_eq("nolatch_cnt",  32'(shift_cnt), 32'd0);
    check_eq("nolatch_data", 32'(data_out), 32'd1);

    // Async reset mid-shift
    do_latch(8'hA5);
    push_frame(8'hA5, 4);
    shift_check(4);
    rst = 1'b1;
    #1;
    check_eq("rst2_data",  32'(data_out), 32'd1);
    check_eq("rst2_cnt",   32'(shift_cnt), 32'd0);
    check_eq("rst2_flags", {29'd0, frame_done, short_frame, extra_clk}, 32'd0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(4);

    // Full frame with every button pressed
    n_fd = 0;
    do_latch(8'hFF);
    push_frame(8'hFF, 8);
    shift_check(8);
    wait_cyc(2);
    check_eq("ff_fd",  32'(n_fd), 32'd1);
    check_eq("ff_cnt", 32'(shift_cnt), 32'd8);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nes_pad_responder
`default_nettype wire

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Device-side model of an NES game pad (4021-style shift register). It answers the latch/clock pulses from the console's controller reader and returns 8 button bits serially on the data line.
- Used in bench and loopback builds: its ports connect to the reader's latch_out, clk_out and data_in nets, so controller_data and the controller interrupt path can be exercised without a physical pad.
- Runs in the clk_25mhz domain. latch_in and pclk_in are treated as asynchronous and are synchronized internally.

Parameters:
- FILT_CYC, 2, number of consecutive identical synchronized samples required before a latch_in/pclk_in level is accepted (1..15).
- FILL_BIT, 1'b0, level driven on data_out after all 8 bits have been shifted out.

Ports:
- clk_25mhz  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- latch_in  in  1  latch from the reader. High means parallel load.
- pclk_in  in  1  serial clock from the reader. A rising edge advances one bit.
- buttons  in  8  pressed=1, order {Right,Left,Down,Up,Start,Select,B,A}, so bit0 = A.
- data_out  out  1  serial data, active-low (pressed bit drives 0).
- shift_cnt  out  4  bits shifted since the last latch. Saturates at 15.
- frame_done  out  1  one-cycle pulse when the 8th bit has been shifted.
- short_frame  out  1  one-cycle pulse when a latch arrives after 1..7 shifts.
- extra_clk  out  1  sticky flag: a pclk rising edge was accepted after the 8th shift. Cleared by the next accepted latch rise.

Behaviour:
- Input conditioning:
  - Each of latch_in and pclk_in passes through a 2-flop synchronizer, then a filter.
  - The filter updates its output level only after FILT_CYC consecutive equal samples; a 4-bit counter per input restarts on any sample change.
  - Rise/fall strobes are one-cycle pulses taken from the filtered levels.
  - Input-to-strobe latency is 2+FILT_CYC cycles.
- Shift register: sreg[7:0]. data_out = ~sreg[0] while the bit index is below 8, and FILL_BIT otherwise.
- States: IDLE, LOAD, SHIFT, DONE.
  - IDLE (after reset): sreg=0, data_out=1. Latch rise -> LOAD.
  - LOAD: sreg <= buttons every cycle (transparent parallel load); shift_cnt=0; pclk edges ignored. Latch fall -> SHIFT.
  - SHIFT: on pclk rise, sreg <= {1'b0, sreg[7:1]} and shift_cnt increments. When shift_cnt goes 7->8: frame_done pulses in the same cycle the register updates, and the state moves to DONE.
  - DONE: data_out=FILL_BIT. Each pclk rise sets extra_clk and increments shift_cnt, saturating at 15.
- Latch rise arriving in SHIFT with shift_cnt 1..7: short_frame pulses, state -> LOAD.
- Latch rise arriving in SHIFT with shift_cnt 0: no pulse, state -> LOAD.
- Latch rise arriving in DONE: state -> LOAD, extra_clk cleared.
- Latch rise and pclk rise strobes in the same cycle: latch wins and the shift is discarded.
- buttons is sampled only in LOAD. Changes during SHIFT/DONE do not affect the current frame.
- Reset asserted mid-frame:
  - All outputs return immediately to data_out=1, shift_cnt=0, frame_done=0, short_frame=0, extra_clk=0.
  - State returns to IDLE; filters and synchronizers clear to 0.
  - After deassert, the pad waits for a fresh latch rise.
- Outputs are registered. data_out changes 1 cycle after the strobe that causes it.

Test Plan:
- Reset then idle: rst pulse, no latch -> data_out=1, shift_cnt=0, all flags 0.
- Nominal frame, buttons=8'b1000_0001 (A+Right), FILT_CYC=2:
  - Latch high for 12 cycles, then 8 pclk pulses, each 6 cycles high and 6 low.
  - data_out sequence is 0,1,1,1,1,1,1,0 (A first); then FILL_BIT=0.
  - frame_done pulses once; shift_cnt=8.
- Glitch rejection: a 1-cycle pclk_in spike in SHIFT -> no shift. A 2-cycle stable pulse -> one shift, shift_cnt +1.
- Short frame: latch, 3 pclk pulses, then latch again -> short_frame pulses once, shift_cnt back to 0, sreg reloaded with the new buttons.
- Over-clocking: 11 pclk pulses after latch -> frame_done once at the 8th, extra_clk=1, shift_cnt=11. The next latch rise clears extra_clk.
- Async reset mid-shift: assert rst after 4 shifts -> outputs at reset values immediately. Deassert, run a full frame with buttons=8'hFF -> eight 0 bits.
